vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter PIXEL_DISPLAY_BIT, default 9, giving the MSB index of the X and Y counters (10-bit counters).
REQ-002 SHALL have parameters H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, giving the horizontal timing in pixels.
REQ-003 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, giving the vertical timing in lines.
REQ-004 SHALL have parameter SYNC_DELAY, default 1, legal range 1..4, giving the pipeline delay of hsync/vsync/video_on relative to X/Y.
REQ-005 SHALL have port clock_25, input, 1 bit: 25 MHz pixel clock; the only clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port X, output, PIXEL_DISPLAY_BIT+1 bits: horizontal pixel counter.
REQ-008 SHALL have port Y, output, PIXEL_DISPLAY_BIT+1 bits: vertical line counter.
REQ-009 SHALL have port hsync, output, 1 bit: horizontal sync, active-low, delayed.
REQ-010 SHALL have port vsync, output, 1 bit: vertical sync, active-low, delayed.
REQ-011 SHALL have port video_on, output, 1 bit: visible-area flag, active-high, delayed.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse on the last pixel of each frame.

Function
REQ-013 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL likewise (default 525).
REQ-014 SHALL increment X by 1 every clock_25 cycle; when X = H_TOTAL-1, X SHALL wrap to 0 on the next cycle.
REQ-015 SHALL increment Y only in a cycle where X = H_TOTAL-1; when Y = V_TOTAL-1 at that point, Y SHALL wrap to 0.
REQ-016 SHALL never drive X >= H_TOTAL or Y >= V_TOTAL, including immediately after reset.
REQ-017 SHALL decode, from the current X/Y: h_active_low = (H_VISIBLE+H_FRONT <= X < H_VISIBLE+H_FRONT+H_SYNC), default X 656..751.
REQ-018 SHALL decode v_active_low = (V_VISIBLE+V_FRONT <= Y < V_VISIBLE+V_FRONT+V_SYNC), default Y 490..491.
REQ-019 SHALL decode vis = (X < H_VISIBLE) and (Y < V_VISIBLE).
REQ-020 SHALL pass the decodes through a SYNC_DELAY-stage register pipeline: the outputs at cycle t SHALL equal hsync = NOT h_active_low, vsync = NOT v_active_low, video_on = vis, each as decoded from X/Y at cycle t-SYNC_DELAY.
REQ-021 SHALL make the SYNC_DELAY pipeline align the syncs with a downstream stage that registers pixel data once per SYNC_DELAY; default 1 matches the one-cycle registered pixel stage.
REQ-022 SHALL assert frame_tick combinationally from the registered counters, high exactly when X = H_TOTAL-1 and Y = V_TOTAL-1, not delayed; exactly one cycle per frame.
REQ-023 SHALL keep the X/Y arithmetic at PIXEL_DISPLAY_BIT+1 bits, with no overflow at the default parameters (max 799 < 1024).

Reset
REQ-024 SHALL, in any cycle with reset=1, load X=0 and Y=0 on that edge, overriding counting.
REQ-025 SHALL, while reset=1, load all pipeline stages with inactive values: hsync=1, vsync=1, video_on=0.
REQ-026 SHALL, for the first SYNC_DELAY cycles after reset deasserts, output the flushed inactive values; from cycle SYNC_DELAY the outputs SHALL reflect X=0,Y=0 onward (video_on=1).
REQ-027 SHALL restart timing identically when reset is asserted mid-frame, leaving no residual sync pulse from the old frame.
REQ-028 SHALL hold frame_tick at 0 in any cycle where reset=1.

Verification
REQ-029 SHALL be verified by holding reset 3 cycles then releasing -> X=0,Y=0; at SYNC_DELAY=1, video_on=0 on the first cycle and 1 on the second; hsync=vsync=1.
REQ-030 SHALL be verified by running one line from X=0 -> X reaches 799, then 0 with Y incremented by 1; hsync low for exactly 96 cycles, its first low cycle being the one after X=656 (delay 1).
REQ-031 SHALL be verified by running a full frame -> Y wraps 524->0; vsync low for exactly 2x800 = 1600 cycles at Y=490..491 (shifted by 1); frame_tick high for exactly 1 cycle in 420000.
REQ-032 SHALL be verified by counting video_on cycles over one frame -> exactly 640x480 = 307200; video_on=0 whenever delayed X>=640 or Y>=480.
REQ-033 SHALL be verified by asserting reset for 1 cycle at X=700,Y=490 (during vsync) -> the next cycle has X=0,Y=0, vsync=1, hsync=1, no remaining sync pulse.
REQ-034 SHALL be verified by re-running the line check with SYNC_DELAY=3 -> hsync/video_on transitions occur 3 cycles after the matching X values; X/Y timing is unchanged.

Source files
------------

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
//   Raster timing generator for a VGA-style display. A free-running
//   horizontal pixel counter (X) and vertical line counter (Y) sweep the whole
//   frame, including the blanking intervals. Sync and visible-area flags are
//   decoded from the counters and sent through a short register pipeline.
//   That pipeline keeps them aligned with a pixel-data path that registers
//   its data SYNC_DELAY times.
//
// Ports
//   clock_25   in   pixel clock (only clock)
//   reset      in   synchronous, active-high
//   X          out  horizontal pixel counter, 0 .. H_TOTAL-1
//   Y          out  vertical line counter,    0 .. V_TOTAL-1
//   hsync      out  horizontal sync, active-low, delayed by SYNC_DELAY
//   vsync      out  vertical sync,   active-low, delayed by SYNC_DELAY
//   video_on   out  visible-area flag, active-high, delayed by SYNC_DELAY
//   frame_tick out  one-cycle pulse on the last pixel of a frame (not delayed)
// ---------------------------------------------------------------------------
module vga_sync #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int H_VISIBLE         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_VISIBLE         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33,
  parameter int SYNC_DELAY        = 1    // legal range 1..4
) (
  input  logic                     clock_25,
  input  logic                     reset,
  output logic [PIXEL_DISPLAY_BIT:0] X,
  output logic [PIXEL_DISPLAY_BIT:0] Y,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     video_on,
  output logic                     frame_tick
);

  localparam int CW      = PIXEL_DISPLAY_BIT + 1;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Counter-width constants so every compare and add is the same width.
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VISIBLE);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  // Pipeline shift registers: bit 0 takes the fresh decode, bit SYNC_DELAY-1
  // drives the output.
  logic [SYNC_DELAY-1:0] hs_q, hs_d;
  logic [SYNC_DELAY-1:0] vs_q, vs_d;
  logic [SYNC_DELAY-1:0] vid_q, vid_d;

  logic h_active_low, v_active_low, vis;
  logic hs_new, vs_new, vid_new;
  logic x_at_end, y_at_end;

  assign x_at_end = (x_q == H_LAST);
  assign y_at_end = (y_q == V_LAST);

  // Y only moves on the last pixel of a line, so both counters wrap together
  // at the end of the frame.
  always_comb begin
    x_d = x_q + ONE;
    y_d = y_q;
    if (x_at_end) begin
      x_d = '0;
      if (y_at_end) y_d = '0;
      else          y_d = y_q + ONE;
    end
  end

  // Decode from the current counter values.
  assign h_active_low = (x_q >= HS_START) && (x_q < HS_END);
  assign v_active_low = (y_q >= VS_START) && (y_q < VS_END);
  assign vis          = (x_q < H_VIS_C) && (y_q < V_VIS_C);

  assign hs_new  = ~h_active_low;
  assign vs_new  = ~v_active_low;
  assign vid_new = vis;

  // Shift left by one and insert the new decode at bit 0. With SYNC_DELAY=1
  // the shift empties the register and only the new decode remains.
  assign hs_d  = (hs_q  << 1) | SYNC_DELAY'(hs_new);
  assign vs_d  = (vs_q  << 1) | SYNC_DELAY'(vs_new);
  assign vid_d = (vid_q << 1) | SYNC_DELAY'(vid_new);

  always_ff @(posedge clock_25) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      // Flush every stage with inactive levels so that no sync pulse from an
      // interrupted frame leaks out after reset.
      hs_q  <= '1;
      vs_q  <= '1;
      vid_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
    end
  end

  assign X        = x_q;
  assign Y        = y_q;
  assign hsync    = hs_q[SYNC_DELAY-1];
  assign vsync    = vs_q[SYNC_DELAY-1];
  assign video_on = vid_q[SYNC_DELAY-1];

  // Taken straight from the counters (not pipelined). It is gated off during
  // reset.
  assign frame_tick = ~reset & x_at_end & y_at_end;

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
//   Three instances share one clock: default timing with SYNC_DELAY=1,
//   default timing with SYNC_DELAY=3, and a shrunken timing with SYNC_DELAY=2.
//   The shrunken timing lets whole frames and mid-frame resets fit in a short
//   run. A reference model predicts every output from the number of cycles
//   since the last reset, using plain division and modulo on the frame
//   geometry.
// ---------------------------------------------------------------------------
module tb_vga_sync;

  // Small-geometry instance: 32 x 21 total, 20 x 12 visible.
  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 12, S_VF = 2, S_VS = 3, S_VB = 4;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
  localparam int S_FR = S_HT * S_VT;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a;   // default-geometry instances
  logic rst_s;   // small-geometry instance

  initial clk = 1'b0;
  always #20 clk = ~clk;

  logic [9:0] x_1, y_1, x_3, y_3;
  logic [5:0] x_s, y_s;
  logic hs_1, vs_1, vid_1, ft_1;
  logic hs_3, vs_3, vid_3, ft_3;
  logic hs_s, vs_s, vid_s, ft_s;

  vga_sync #(.SYNC_DELAY(1)) u_d1 (
    .clock_25(clk), .reset(rst_a), .X(x_1), .Y(y_1),
    .hsync(hs_1), .vsync(vs_1), .video_on(vid_1), .frame_tick(ft_1)
  );

  vga_sync #(.SYNC_DELAY(3)) u_d3 (
    .clock_25(clk), .reset(rst_a), .X(x_3), .Y(y_3),
    .hsync(hs_3), .vsync(vs_3), .video_on(vid_3), .frame_tick(ft_3)
  );

  vga_sync #(
    .PIXEL_DISPLAY_BIT(5),
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .SYNC_DELAY(2)
  ) u_sm (
    .clock_25(clk), .reset(rst_s), .X(x_s), .Y(y_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vid_s), .frame_tick(ft_s)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int n_a      = 0;  // cycles since the last reset edge, default instances
  int n_s      = 0;  // same for the small instance

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model. The counters give the raster position n cycles after
  // reset. The delayed flags describe the position d cycles earlier, and
  // they are at their inactive levels until that many cycles have passed.
  task automatic check_dut(
    input string tag, input int n, input int d,
    input int hv, input int hf, input int hsw, input int hb,
    input int vv, input int vf, input int vsw, input int vb,
    input bit rst,
    input logic [15:0] xo, input logic [15:0] yo,
    input logic hso, input logic vso, input logic vido, input logic fto);
    int ht, vt, ex, ey, p, px, py;
    logic ehs, evs, evid, eft;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ex = n % ht;
    ey = (n / ht) % vt;
    if (n < d) begin
      ehs = 1'b1; evs = 1'b1; evid = 1'b0;
    end else begin
      p    = n - d;
      px   = p % ht;
      py   = (p / ht) % vt;
      ehs  = !((px >= hv + hf) && (px < hv + hf + hsw));
      evs  = !((py >= vv + vf) && (py < vv + vf + vsw));
      evid = (px < hv) && (py < vv);
    end
    eft = !rst && (ex == ht - 1) && (ey == vt - 1);
    chk({tag, "_x"},   xo, 16'(ex));
    chk({tag, "_y"},   yo, 16'(ey));
    chk({tag, "_hs"},  {15'd0, hso},  {15'd0, ehs});
    chk({tag, "_vs"},  {15'd0, vso},  {15'd0, evs});
    chk({tag, "_vid"}, {15'd0, vido}, {15'd0, evid});
    chk({tag, "_ft"},  {15'd0, fto},  {15'd0, eft});
  endtask

  // ---------------- driver ----------------
  // One clock: the reset values seen at the edge update the model, and all
  // outputs are compared 1 time unit after the edge.
  task automatic tick();
    bit ra, rs;
    ra = rst_a;
    rs = rst_s;
    @(posedge clk);
    #1;
    if (ra) n_a = 0; else n_a++;
    if (rs) n_s = 0; else n_s++;
    check_dut("d1", n_a, 1, 640, 16, 96, 48, 480, 10, 2, 33, rst_a,
              16'(x_1), 16'(y_1), hs_1, vs_1, vid_1, ft_1);
    check_dut("d3", n_a, 3, 640, 16, 96, 48, 480, 10, 2, 33, rst_a,
              16'(x_3), 16'(y_3), hs_3, vs_3, vid_3, ft_3);
    check_dut("sm", n_s, 2, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, rst_s,
              16'(x_s), 16'(y_s), hs_s, vs_s, vid_s, ft_s);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt_hs1, first_hs1, cnt_hs3, first_hs3, first_vidoff3;
    int cnt_vs_s, cnt_vid_s, cnt_ft_s, k, len, rl;

    rst_a = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);

    // Hold reset for three cycles.
    repeat (3) tick();
    chk("rst_x1",   16'(x_1), 16'd0);
    chk("rst_y1",   16'(y_1), 16'd0);
    chk("rst_vid1", {15'd0, vid_1}, 16'd0);
    chk("rst_hs1",  {15'd0, hs_1},  16'd1);
    chk("rst_vs1",  {15'd0, vs_1},  16'd1);

    rst_a = 1'b0;
    rst_s = 1'b0;
    tick();
    chk("rel_vid1", {15'd0, vid_1}, 16'd1);
    chk("rel_x1",   16'(x_1), 16'd1);

    // Run a bit over two default lines, which is also more than two small
    // frames. Aggregate statistics are gathered over the whole run.
    cnt_hs1 = 0; first_hs1 = -1; cnt_hs3 = 0; first_hs3 = -1; first_vidoff3 = -1;
    cnt_vs_s = 0; cnt_vid_s = 0; cnt_ft_s = 0;
    for (int i = 2; i <= 1800; i++) begin
      tick();
      if (n_a >= 1 && n_a <= 800 && hs_1 == 1'b0) begin
        cnt_hs1++;
        if (first_hs1 < 0) first_hs1 = n_a;
      end
      if (n_a >= 3 && n_a <= 802 && hs_3 == 1'b0) begin
        cnt_hs3++;
        if (first_hs3 < 0) first_hs3 = n_a;
      end
      if (n_a >= 3 && vid_3 == 1'b0 && first_vidoff3 < 0) first_vidoff3 = n_a;
      if (n_s >= 2 && n_s < 2 + S_FR) begin
        if (vs_s == 1'b0) cnt_vs_s++;
        if (vid_s == 1'b1) cnt_vid_s++;
      end
      if (n_s >= 1 && n_s <= S_FR && ft_s == 1'b1) cnt_ft_s++;
      if (n_a == 799) chk("line_end_x", 16'(x_1), 16'd799);
      if (n_a == 800) begin
        chk("line_wrap_x", 16'(x_1), 16'd0);
        chk("line_wrap_y", 16'(y_1), 16'd1);
      end
      if (n_s == S_FR - 1) chk("frame_end_y", 16'(y_s), 16'(S_VT - 1));
      if (n_s == S_FR)     chk("frame_wrap_y", 16'(y_s), 16'd0);
    end
    chk("hs_low_cnt_d1",   16'(cnt_hs1), 16'd96);
    chk("hs_first_low_d1", 16'(first_hs1), 16'd657);
    chk("hs_low_cnt_d3",   16'(cnt_hs3), 16'd96);
    chk("hs_first_low_d3", 16'(first_hs3), 16'd659);
    chk("vid_off_d3",      16'(first_vidoff3), 16'd643);
    chk("vs_low_cnt_sm",   16'(cnt_vs_s), 16'(S_VS * S_HT));
    chk("vid_cnt_sm",      16'(cnt_vid_s), 16'(S_HV * S_VV));
    chk("ft_cnt_sm",       16'(cnt_ft_s), 16'd1);

    // Reset the small instance while it is inside both sync pulses.
    k = 0;
    while (!(((n_s % S_HT) == S_HV + S_HF + 2) && (((n_s / S_HT) % S_VT) == S_VV + S_VF))
           && k < S_FR + 10) begin
      tick();
      k++;
    end
    chk("mid_reset_reached", 16'(k < S_FR + 10), 16'd1);
    chk("mid_vs_active", {15'd0, vs_s}, 16'd0);
    rst_s = 1'b1;
    tick();
    chk("mid_rst_x",  16'(x_s), 16'd0);
    chk("mid_rst_y",  16'(y_s), 16'd0);
    chk("mid_rst_vs", {15'd0, vs_s}, 16'd1);
    chk("mid_rst_hs", {15'd0, hs_s}, 16'd1);
    rst_s = 1'b0;
    repeat (2) begin
      tick();
      chk("post_rst_vs", {15'd0, vs_s}, 16'd1);
      chk("post_rst_hs", {15'd0, hs_s}, 16'd1);
    end

    // Random run lengths with random resets of random length; the model
    // checks every cycle.
    repeat (16) begin
      len = $urandom_range(50, 1500);
      repeat (len) tick();
      if ($urandom_range(0, 1) == 1) rst_a = 1'b1;
      else                           rst_s = 1'b1;
      rl = $urandom_range(1, 3);
      repeat (rl) tick();
      rst_a = 1'b0;
      rst_s = 1'b0;
    end
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
